// File: rtl/clock_enable_scheduler.sv
// Master-clock enable generator for the NES CPU/PPU/VGA domains with MCU halt/step control.
// Optional single-step support is built when CLOCK_ENABLE_SCHEDULER_STEP_EN is defined.
module clock_enable_scheduler #(
  parameter int unsigned CPU_DIV = 12,
  parameter int unsigned PPU_DIV = 4,
  parameter int unsigned VGA_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_halt_req,
  input  logic        i_step_req,
  output logic        o_ce_cpu,
  output logic        o_ce_ppu,
  output logic        o_ce_vga,
  output logic        o_halted,
  output logic        o_step_done,
  output logic [15:0] o_cpu_cycles
);

  localparam int unsigned PHASE_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int unsigned VGA_W   = (VGA_DIV > 1) ? $clog2(VGA_DIV) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    ,S_STEP  = 2'd2
`endif
  } state_t;

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase, phase_next;
  logic [VGA_W-1:0]   vga_cnt;
  logic               step_done_next;
  logic               active;
  logic               phase_last;
  logic               vga_last;

`ifndef CLOCK_ENABLE_SCHEDULER_STEP_EN
  logic unused_step_req;
  assign unused_step_req = i_step_req;
`endif

  assign active     = (state != S_HALTED);
  assign phase_last = (32'(phase) == CPU_DIV - 1);
  assign vga_last   = (32'(vga_cnt) == VGA_DIV - 1);

  assign o_ce_cpu = active && phase_last;
  assign o_ce_ppu = active && ((32'(phase) % PPU_DIV) == (PPU_DIV - 1));
  assign o_ce_vga = vga_last;
  assign o_halted = (state == S_HALTED);

  // State, phase, step-done and cycle counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_RUN;
      phase        <= '0;
      o_step_done  <= 1'b0;
      o_cpu_cycles <= 16'd0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      o_step_done <= step_done_next;
      if (o_ce_cpu) begin
        o_cpu_cycles <= o_cpu_cycles + 16'd1;
      end
    end
  end

  // Pixel enable is never gated by the debugger
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vga_cnt <= '0;
    end else begin
      vga_cnt <= vga_last ? '0 : vga_cnt + VGA_W'(1);
    end
  end

  // Next-state: halts and steps only take effect on a CPU cycle boundary
  always_comb begin
    state_next     = state;
    phase_next     = phase;
    step_done_next = 1'b0;
    case (state)
      S_RUN: begin
        phase_next = phase_last ? '0 : phase + PHASE_W'(1);
        if (phase_last && i_halt_req) begin
          state_next = S_HALTED;
        end
      end
      S_HALTED: begin
        phase_next = '0;
        if (!i_halt_req) begin
          state_next = S_RUN;
        end
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
        else if (i_step_req) begin
          state_next = S_STEP;
        end
`endif
      end
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
      S_STEP: begin
        phase_next = phase_last ? '0 : phase + PHASE_W'(1);
        if (phase_last) begin
          state_next     = i_halt_req ? S_HALTED : S_RUN;
          step_done_next = 1'b1;
        end
      end
`endif
      default: begin
        state_next = S_RUN;
        phase_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Scoreboard bench for clock_enable_scheduler: expected CPU/step/halt events are queued
// with their edge numbers and matched by an independent monitor.
module tb_clock_enable_scheduler;

  localparam int EV_CPU  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_HALT = 2;
  localparam int EV_RUN  = 3;

  typedef struct {
    int          kind;
    int          edge_no;
    logic [15:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic        ce_cpu, ce_ppu, ce_vga, halted, step_done;
  logic [15:0] cycles;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  edge_n;
  int  ppu_cnt = 0;
  int  vga_cnt = 0;
  logic halted_prev = 1'b0;

  clock_enable_scheduler dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_halt_req   (halt_req),
    .i_step_req   (step_req),
    .o_ce_cpu     (ce_cpu),
    .o_ce_ppu     (ce_ppu),
    .o_ce_vga     (ce_vga),
    .o_halted     (halted),
    .o_step_done  (step_done),
    .o_cpu_cycles (cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic expect_ev(input int kind, input int edge_no, input int cyc);
    ev_t e;
    e.kind = kind;
    e.edge_no = edge_no;
    e.cyc = 16'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, edge_n);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_edge", edge_n, e.edge_no);
      if (kind == EV_CPU) chk("event_cycles", int'(cycles), int'(e.cyc));
    end
  endtask

  // Monitor: samples just after each active edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      halted_prev = 1'b0;
    end else begin
      if (ce_ppu) ppu_cnt++;
      if (ce_vga) vga_cnt++;
      if (ce_cpu) match(EV_CPU);
      if (step_done) match(EV_DONE);
      if (halted != halted_prev) match(halted ? EV_HALT : EV_RUN);
      halted_prev = halted;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ce_cpu", int'(ce_cpu), 0);
    chk("rst_ce_ppu", int'(ce_ppu), 0);
    chk("rst_ce_vga", int'(ce_vga), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_step_done", int'(step_done), 0);
    chk("rst_cycles", int'(cycles), 0);
    @(negedge clk);
    @(negedge clk);
    halt_req = 1'b0;
    step_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic free_run_24();
    int p0, v0;
    p0 = ppu_cnt;
    v0 = vga_cnt;
    expect_ev(EV_CPU, 11, 0);
    expect_ev(EV_CPU, 23, 1);
    tick(24);
    chk("run_ppu_count", ppu_cnt - p0, 6);
    chk("run_vga_count", vga_cnt - v0, 12);
    chk("run_cycles", int'(cycles), 2);
    chk("run_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int p0, v0;
    @(negedge clk);

    // Reset then free run
    do_reset();
    free_run_24();

    // Halt requested mid CPU cycle
    do_reset();
    expect_ev(EV_CPU, 11, 0);
    expect_ev(EV_HALT, 12, 0);
    tick(5);
    halt_req = 1'b1;
    tick(7);
    chk("halt_halted", int'(halted), 1);
    p0 = ppu_cnt;
    v0 = vga_cnt;
    tick(12);
    chk("halt_ppu_count", ppu_cnt - p0, 0);
    chk("halt_vga_count", vga_cnt - v0, 6);

    // Single step with halt held
    p0 = ppu_cnt;
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    expect_ev(EV_RUN, 25, 0);
    expect_ev(EV_CPU, 36, 1);
    expect_ev(EV_DONE, 37, 0);
    expect_ev(EV_HALT, 37, 0);
`endif
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(13);
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    chk("step_ppu_count", ppu_cnt - p0, 3);
    chk("step_cycles", int'(cycles), 2);
`else
    chk("step_ppu_count", ppu_cnt - p0, 0);
    chk("step_cycles", int'(cycles), 1);
`endif
    chk("step_halted", int'(halted), 1);
    chk("step_queue_empty", exp_q.size(), 0);

    // Release and step on the same edge: resume wins
    expect_ev(EV_RUN, 39, 0);
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    expect_ev(EV_CPU, 50, 2);
    expect_ev(EV_CPU, 62, 3);
`else
    expect_ev(EV_CPU, 50, 1);
    expect_ev(EV_CPU, 62, 2);
`endif
    expect_ev(EV_HALT, 63, 0);
    halt_req = 1'b0;
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(12);
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    chk("resume_cycles", int'(cycles), 3);
`else
    chk("resume_cycles", int'(cycles), 2);
`endif

    // Halt again, start a step, reset at step phase 6
    halt_req = 1'b1;
    tick(12);
    chk("rehalt_halted", int'(halted), 1);
`ifdef CLOCK_ENABLE_SCHEDULER_STEP_EN
    expect_ev(EV_RUN, 64, 0);
`endif
    step_req = 1'b1;
    tick(1);
    step_req = 1'b0;
    tick(6);
    chk("prereset_queue_empty", exp_q.size(), 0);
    do_reset();
    free_run_24();

    // Cycle counter wrap
    force dut.o_cpu_cycles = 16'hFFFF;
    #1;
    release dut.o_cpu_cycles;
    expect_ev(EV_CPU, 35, 16'hFFFF);
    @(negedge clk);
    tick(11);
    chk("wrap_cycles", int'(cycles), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
